// File: rtl/scarf_spi_initiator.sv
// SCARF SPI initiator: sends header {rnw, slave_id}, then cmd_len payload bytes.
// SPI mode 0, MSB first. Every payload byte captured on miso is returned on the rx stream.
module scarf_spi_initiator #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_GAP   = 4,
   parameter int unsigned LEN_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_rnw,
   input  logic [6:0]       cmd_slave_id,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             ss_n,
   output logic             mosi,
   input  logic             miso
);

   localparam int unsigned T_A   = (2 * CLK_DIV > CS_SETUP) ? 2 * CLK_DIV : CS_SETUP;
   localparam int unsigned T_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
   localparam int unsigned T_MAX = (T_A > T_B) ? T_A : T_B;
   localparam int unsigned CNT_W = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {StIdle, StSetup, StShift, StLoad, StHold, StGap} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_q;
   logic [LEN_W-1:0] rem_q;
   logic [6:0]       sh_tx_q;
   logic [6:0]       sh_rx_q;
   logic             hdr_q;
   logic             sclk_q, ss_n_q, mosi_q, done_q, rx_valid_q;
   logic [7:0]       rx_data_q;

   logic rise_edge, fall_edge, byte_end;

   assign rise_edge = (state_q == StShift) && (cnt_q == CNT_W'(CLK_DIV - 1));
   assign fall_edge = (state_q == StShift) && (cnt_q == CNT_W'(2 * CLK_DIV - 1));
   assign byte_end  = fall_edge && (bit_q == 3'd7);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (cmd_valid) state_d = StSetup;
         StSetup: if (cnt_q == CNT_W'(CS_SETUP - 1)) state_d = StShift;
         StShift: if (byte_end) state_d = (rem_q != '0) ? StLoad : StHold;
         StLoad:  if (tx_valid) state_d = StShift;
         StHold:  if (cnt_q == CNT_W'(CS_HOLD - 1)) state_d = StGap;
         StGap:   if (cnt_q == CNT_W'(CS_GAP - 1)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == StIdle);
      tx_ready  = (state_q == StLoad);
      busy      = (state_q != StIdle);
   end

   // Datapath: phase timer, shifters and the registered SPI pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         bit_q      <= '0;
         rem_q      <= '0;
         sh_tx_q    <= '0;
         sh_rx_q    <= '0;
         hdr_q      <= 1'b0;
         sclk_q     <= 1'b0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         ss_n_q     <= !(state_d inside {StSetup, StShift, StLoad, StHold});
         if (state_d != state_q || fall_edge) begin
            cnt_q <= '0;
         end else if (state_q != StIdle && state_q != StLoad) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  mosi_q  <= cmd_rnw;
                  sh_tx_q <= cmd_slave_id;
                  rem_q   <= cmd_len;
                  hdr_q   <= 1'b1;
                  bit_q   <= '0;
               end
            end
            StShift: begin
               if (rise_edge) begin
                  sclk_q  <= 1'b1;
                  sh_rx_q <= {sh_rx_q[5:0], miso};
                  if (bit_q == 3'd7 && !hdr_q) begin
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= {sh_rx_q, miso};
                  end
               end
               if (fall_edge) begin
                  sclk_q <= 1'b0;
                  bit_q  <= bit_q + 3'd1;
                  // Keep bit0 on mosi across LOAD/HOLD; nothing samples it there.
                  if (bit_q != 3'd7) begin
                     mosi_q  <= sh_tx_q[6];
                     sh_tx_q <= {sh_tx_q[5:0], 1'b0};
                  end
               end
            end
            StLoad: begin
               if (tx_valid) begin
                  mosi_q  <= tx_data[7];
                  sh_tx_q <= tx_data[6:0];
                  rem_q   <= rem_q - LEN_W'(1);
                  hdr_q   <= 1'b0;
               end
            end
            StGap: begin
               if (state_d == StIdle) begin
                  done_q <= 1'b1;
                  mosi_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign sclk     = sclk_q;
   assign ss_n     = ss_n_q;
   assign mosi     = mosi_q;
   assign done     = done_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_scarf_spi_initiator.sv
// Bench for scarf_spi_initiator: vector table, random transactions vs. a transaction-level
// model, plus hand-written reset-abort and back-to-back sequences.
module tb_scarf_spi_initiator;

   localparam int unsigned CD  = 4;
   localparam int unsigned CSS = 2;
   localparam int unsigned CSH = 2;
   localparam int unsigned CSG = 4;
   localparam int unsigned LW  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_rnw = 1'b0;
   logic [6:0]    cmd_slave_id = '0;
   logic [LW-1:0] cmd_len = '0;
   logic [7:0]    tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic [7:0]    rx_data;
   logic          rx_valid, busy, done, sclk, ss_n, mosi, miso;

   always #5 clk = ~clk;

   scarf_spi_initiator #(
      .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_GAP(CSG), .LEN_W(LW)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rnw(cmd_rnw), .cmd_slave_id(cmd_slave_id), .cmd_len(cmd_len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
      .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso)
   );

   int chk_cnt = 0;
   int pass_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Slave byte image (slot 0 = header time, discarded) and tx source image.
   logic [7:0] slave_mem [32];
   logic [7:0] tx_mem    [32];
   int         tx_wait   [32];
   int         tx_n = 0, tx_idx = 0, hs_cnt = 0;
   bit         tx_pend = 0;

   // Expected results, filled per transaction.
   logic [7:0] exp_mosi [33];
   logic [7:0] exp_rx   [32];
   int         exp_loads;

   int  cyc = 0, nrise = 0, load_cnt = 0, done_cnt = 0, acc_cnt = 0, t_acc = 0, t_done = 0;
   int  stall_err = 0, sclk_err = 0, busy_err = 0, hi_run = 0, min_gap = 1000;
   bit  seen_low = 0, prev_sclk = 0;
   logic [7:0] cur = '0;
   logic [7:0] mosi_q [$];
   logic [7:0] rx_q   [$];
   int  d0, a0;

   // Slave drives the bit for the next sclk rise; it changes only during sclk-high.
   assign miso = slave_mem[nrise[7:3]][3'(7 - (nrise % 8))];

   initial forever begin
      @(negedge clk);
      cyc++;
      if (cmd_valid && cmd_ready) begin
         acc_cnt++;
         t_acc    = cyc;
         nrise    = 0;
         load_cnt = 0;
      end
      if (tx_ready) begin
         load_cnt++;
         if (sclk || ss_n) stall_err++;
      end
      if (sclk && !prev_sclk) begin
         cur = {cur[6:0], mosi};
         nrise++;
         if (nrise % 8 == 0) mosi_q.push_back(cur);
      end
      if (rx_valid) rx_q.push_back(rx_data);
      if (done) begin
         done_cnt++;
         t_done = cyc;
      end
      if (ss_n && sclk) sclk_err++;
      if (busy == cmd_ready) busy_err++;
      if (ss_n) hi_run++;
      else begin
         if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
         seen_low = 1;
         hi_run   = 0;
      end
      prev_sclk = sclk;
   end

   // tx source: byte i is withheld for tx_wait[i] cycles of tx_ready.
   initial forever begin
      @(negedge clk);
      if (tx_pend) begin
         tx_idx++;
         hs_cnt++;
         tx_pend = 0;
      end
      if (tx_idx < tx_n) begin
         if (tx_ready && tx_wait[tx_idx] > 0) tx_wait[tx_idx]--;
         tx_valid = (tx_wait[tx_idx] == 0);
         tx_data  = tx_mem[tx_idx];
      end else begin
         tx_valid = 1'b0;
      end
      tx_pend = tx_valid && tx_ready;
   end

   task automatic start_txn(input bit rnw, input bit [6:0] id, input int len);
      tx_n = len; tx_idx = 0; tx_pend = 0; hs_cnt = 0;
      mosi_q.delete(); rx_q.delete();
      stall_err = 0; sclk_err = 0;
      d0 = done_cnt; a0 = acc_cnt;
      @(posedge clk); #1;
      cmd_rnw = rnw; cmd_slave_id = id; cmd_len = LW'(len); cmd_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (acc_cnt != a0) break;
      end
      cmd_valid = 1'b0;
      chk("accept", acc_cnt - a0, 1);
   endtask

   task automatic finish_txn(input string tag, input int len);
      for (int i = 0; i < 5000 && done_cnt == d0; i++) @(negedge clk);
      chk({tag, ".done"}, done_cnt - d0, 1);
      chk({tag, ".nbytes"}, mosi_q.size(), len + 1);
      for (int i = 0; i <= len && i < mosi_q.size(); i++)
         chk((i == 0) ? {tag, ".hdr"} : {tag, ".mosi"}, mosi_q[i], exp_mosi[i]);
      chk({tag, ".nrx"}, rx_q.size(), len);
      for (int i = 0; i < len && i < rx_q.size(); i++) chk({tag, ".rx"}, rx_q[i], exp_rx[i]);
      chk({tag, ".rises"}, nrise, 8 * (len + 1));
      chk({tag, ".tx_taken"}, hs_cnt, len);
      chk({tag, ".cycles"}, t_done - t_acc, 1 + CSS + (1 + len) * 16 * CD + CSH + CSG + exp_loads);
      chk({tag, ".stall_pins"}, stall_err, 0);
      chk({tag, ".sclk_idle"}, sclk_err, 0);
   endtask

   // Transaction-level model: what the wire and rx stream must carry.
   task automatic model(input bit rnw, input bit [6:0] id, input int len);
      exp_mosi[0] = {rnw, id};
      exp_loads = 0;
      for (int i = 0; i < len; i++) begin
         exp_mosi[i + 1] = tx_mem[i];
         exp_rx[i]       = slave_mem[i + 1];
         exp_loads += (tx_wait[i] > 1) ? tx_wait[i] : 1;
      end
   endtask

   typedef struct {
      bit        rnw;
      bit [6:0]  id;
      int        len;
      bit [31:0] tx;
      bit [31:0] sl;
      int        stall_byte;
      int        stall_len;
      bit [7:0]  exp_hdr;
      bit [31:0] exp_rx;
   } vec_t;

   vec_t vecs [4];

   initial begin
      bit        rnw;
      bit [6:0]  id;
      int        len;

      vecs[0] = '{1'b0, 7'h02, 3, 32'h00A5_1000, 32'h0, -1, 0, 8'h02, 32'h0};
      vecs[1] = '{1'b1, 7'h04, 2, 32'h0,         32'h0000_C33C, -1, 0, 8'h84, 32'h0000_C33C};
      vecs[2] = '{1'b1, 7'h7F, 0, 32'h0,         32'h0, -1, 0, 8'hFF, 32'h0};
      vecs[3] = '{1'b0, 7'h11, 3, 32'h0056_3412, 32'h009A_BCDE, 1, 51, 8'h11, 32'h009A_BCDE};
      for (int i = 0; i < 32; i++) begin
         slave_mem[i] = '0; tx_mem[i] = '0; tx_wait[i] = 0;
      end

      repeat (3) @(negedge clk);
      chk("rst.cmd_ready", cmd_ready, 1);
      chk("rst.tx_ready", tx_ready, 0);
      chk("rst.rx_data", rx_data, 0);
      chk("rst.rx_valid", rx_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.sclk", sclk, 0);
      chk("rst.ss_n", ss_n, 1);
      chk("rst.mosi", mosi, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         slave_mem[0] = 8'($urandom);
         for (int i = 0; i < 4; i++) begin
            slave_mem[i + 1] = vecs[v].sl[8 * i +: 8];
            tx_mem[i]        = vecs[v].tx[8 * i +: 8];
            tx_wait[i]       = (i == vecs[v].stall_byte) ? vecs[v].stall_len : 0;
         end
         exp_loads   = 0;
         exp_mosi[0] = vecs[v].exp_hdr;
         for (int i = 0; i < vecs[v].len; i++) begin
            exp_mosi[i + 1] = vecs[v].tx[8 * i +: 8];
            exp_rx[i]       = vecs[v].exp_rx[8 * i +: 8];
            exp_loads += (tx_wait[i] > 1) ? tx_wait[i] : 1;
         end
         start_txn(vecs[v].rnw, vecs[v].id, vecs[v].len);
         finish_txn($sformatf("vec%0d", v), vecs[v].len);
      end

      for (int n = 0; n < 11; n++) begin
         rnw = 1'($urandom);
         id  = 7'($urandom);
         len = (n == 10) ? 15 : int'($urandom_range(0, 6));
         for (int i = 0; i < 32; i++) begin
            slave_mem[i] = 8'($urandom);
            tx_mem[i]    = 8'($urandom);
            tx_wait[i]   = (n == 10) ? 0 : int'($urandom_range(0, 3));
         end
         model(rnw, id, len);
         start_txn(rnw, id, len);
         finish_txn($sformatf("rnd%0d", n), len);
      end

      // Reset in the middle of payload byte 1, then a clean write of 0x5A.
      for (int i = 0; i < 32; i++) begin
         tx_mem[i] = 8'h11 + 8'(i); tx_wait[i] = 0; slave_mem[i] = 8'hE7;
      end
      start_txn(1'b0, 7'h33, 2);
      for (int i = 0; i < 2000 && nrise < 12; i++) @(negedge clk);
      chk("abort.reached", nrise, 12);
      #1 reset = 1'b1;
      tx_n = 0; tx_pend = 0;
      @(negedge clk);
      chk("abort.ss_n", ss_n, 1);
      chk("abort.sclk", sclk, 0);
      chk("abort.mosi", mosi, 0);
      chk("abort.busy", busy, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort.no_done", done_cnt - d0, 0);
      chk("abort.no_rx", rx_q.size(), 0);
      tx_mem[0] = 8'h5A; tx_wait[0] = 0; slave_mem[1] = 8'h96;
      model(1'b0, 7'h2A, 1);
      start_txn(1'b0, 7'h2A, 1);
      finish_txn("post_rst", 1);

      // Back-to-back header-only commands with cmd_valid held high.
      tx_n = 0; d0 = done_cnt; a0 = acc_cnt;
      seen_low = 0; min_gap = 1000; busy_err = 0;
      @(posedge clk); #1;
      cmd_rnw = 1'b1; cmd_slave_id = 7'h55; cmd_len = '0; cmd_valid = 1'b1;
      for (int i = 0; i < 2000 && acc_cnt < a0 + 2; i++) begin
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 2000 && done_cnt < d0 + 2; i++) @(negedge clk);
      chk("b2b.accepts", acc_cnt - a0, 2);
      chk("b2b.dones", done_cnt - d0, 2);
      chk("b2b.gap_ok", (min_gap >= CSG && min_gap < 1000) ? 1 : 0, 1);
      chk("b2b.ready_vs_busy", busy_err, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
